rx_control: RTL and testbench

- Receive control unit for the serial receiver.
- Synchronizes the raw serial line and detects the start bit (high-to-low edge).
- Qualifies the start bit at mid-bit, then drives enable_timer to the bit timer (10-clock shift_strobe, packet_done after 9 strobes).
- Consumes packet_done, checks the stop bit, and either pulses load_buffer to the RX data buffer or raises framing_error.

---
 rtl/rx_control.sv | 161 ++++++++++++++++
 tb/tb_rx_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_control.sv
// -----------------------------------------------------------------------------
// rx_control
//   Receive control unit for the serial receiver. Synchronizes the raw serial
//   line, detects the start-bit falling edge, qualifies it at mid-bit, runs the
//   external bit timer for the data bits, then checks the stop bit and either
//   loads the RX buffer or flags a framing error.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   serial_in     in   raw serial line (idle high), asynchronous to clk
//   packet_done   in   bit timer level: 9 shift strobes have occurred
//   stop_bit      in   stop-bit value captured by the receive shift register
//   enable_timer  out  high only while receiving; low clears the bit timer
//   load_buffer   out  one-cycle pulse: move received byte into RX buffer
//   framing_error out  sticky error flag for the last packet
//   false_start   out  one-cycle pulse: start edge failed mid-bit check
//   rx_busy       out  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module rx_control #(
  parameter int HALF_BIT = 5,  // clocks from start edge to mid-bit resample
  parameter int CNT_W    = 3   // must hold HALF_BIT-1
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic packet_done,
  input  logic stop_bit,
  output logic enable_timer,
  output logic load_buffer,
  output logic framing_error,
  output logic false_start,
  output logic rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_QUAL,
    S_RECV,
    S_STOP_CHK,
    S_LOAD,
    S_FRAME_ERR
  } state_t;

  localparam logic [CNT_W-1:0] LP_QUAL_LAST = CNT_W'(HALF_BIT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             r_enable_timer;
  logic             r_load_buffer;
  logic             r_framing_error;
  logic             r_false_start;
  logic             r_rx_busy;
  logic             w_start_edge;

  // Falling edge of the synchronized line; r_s3 is r_s2 one clock earlier.
  assign w_start_edge = r_s3 & ~r_s2;

  // Two-flop synchronizer plus an edge-history flop. Idle line is high, so
  // all three reset to 1 to avoid a phantom start edge after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, forming a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= serial_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Control FSM. Outputs are registered and updated on the same edge as the
  // state they belong to, so each output is a clean flop tied to its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_enable_timer  <= 1'b0;
      r_load_buffer   <= 1'b0;
      r_framing_error <= 1'b0;
      r_false_start   <= 1'b0;
      r_rx_busy       <= 1'b0;
    end else begin
      // Pulse outputs default low; only a transition raises them for a cycle.
      r_load_buffer <= 1'b0;
      r_false_start <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state   <= S_START_QUAL;
            r_cnt     <= '0;
            r_rx_busy <= 1'b1;
          end
        end

        S_START_QUAL: begin
          if (r_cnt != LP_QUAL_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (!r_s2) begin
            // Line still low at mid-bit: genuine start bit.
            r_state         <= S_RECV;
            r_enable_timer  <= 1'b1;
            r_framing_error <= 1'b0;
          end else begin
            r_state       <= S_IDLE;
            r_false_start <= 1'b1;
            r_rx_busy     <= 1'b0;
          end
        end

        S_RECV: begin
          if (packet_done) begin
            // Dropping enable_timer also clears the bit timer.
            r_state        <= S_STOP_CHK;
            r_enable_timer <= 1'b0;
          end
        end

        S_STOP_CHK: begin
          if (stop_bit) begin
            r_state       <= S_LOAD;
            r_load_buffer <= 1'b1;
          end else begin
            r_state <= S_FRAME_ERR;
          end
        end

        S_LOAD: begin
          r_state   <= S_IDLE;
          r_rx_busy <= 1'b0;
        end

        S_FRAME_ERR: begin
          r_state         <= S_IDLE;
          r_framing_error <= 1'b1;
          r_rx_busy       <= 1'b0;
        end

        default: begin
          r_state        <= S_IDLE;
          r_enable_timer <= 1'b0;
          r_rx_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign enable_timer  = r_enable_timer;
  assign load_buffer   = r_load_buffer;
  assign framing_error = r_framing_error;
  assign false_start   = r_false_start;
  assign rx_busy       = r_rx_busy;

endmodule

// File: tb/tb_rx_control.sv
// -----------------------------------------------------------------------------
// tb_rx_control
//   Self-checking bench for rx_control. A waveform of serial-line samples is
//   built per run; a reference model derives, from the frame-level timing
//   rules, the expected output of every cycle. A behavioural bit timer drives
//   packet_done 90 clocks after enable_timer rises.
// -----------------------------------------------------------------------------
module tb_rx_control;

  localparam int MAXN     = 4096;
  localparam int HB       = 5;          // HALF_BIT
  localparam int TIMER    = 90;         // clocks of enable_timer before packet_done
  localparam int LAT_EN   = 2 + HB;     // start edge sample -> RECV entry
  localparam int STOP_CHK = LAT_EN + TIMER;  // index of STOP_CHK cycle
  localparam int LOAD_AT  = STOP_CHK + 1;    // index of LOAD / FRAME_ERR cycle

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic packet_done;
  logic stop_bit;
  logic enable_timer;
  logic load_buffer;
  logic framing_error;
  logic false_start;
  logic rx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus waveform: line_w[k]/stop_w[k] are sampled by the DUT at edge k.
  bit line_w [MAXN];
  bit stop_w [MAXN];
  int wr_idx;

  // Model outputs and observed outputs per cycle (observed #1 after edge k).
  bit       m_en   [MAXN];
  bit       m_ld   [MAXN];
  bit       m_fs   [MAXN];
  bit       m_fe   [MAXN];
  bit       m_busy [MAXN];
  int       fe_evt [MAXN];
  bit [4:0] obs    [MAXN];

  bit fe_start;        // framing_error level the DUT holds as a run begins
  int run_id = 0;
  int tcnt;
  int invariant_bad = 0;

  typedef struct {
    int low_len;   // clocks the line stays low from the start edge
    bit stop;      // stop_bit presented for this frame
    int exp_ld;    // load_buffer pulses in the window
    int exp_fs;    // false_start pulses in the window
    int exp_en;    // enable_timer high cycles in the window
    int exp_rise;  // clocks from start edge to enable_timer rise, -1 if none
    bit exp_fe;    // framing_error at end of the window
  } vec_t;

  vec_t tbl [9];
  int   tbl_start [9];
  int   tbl_len   [9];

  always #5 clk = ~clk;

  rx_control #(.HALF_BIT(HB), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .packet_done  (packet_done),
    .stop_bit     (stop_bit),
    .enable_timer (enable_timer),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .false_start  (false_start),
    .rx_busy      (rx_busy)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic put(input bit v, input int len, input bit sb);
    for (int i = 0; i < len; i++) begin
      if (wr_idx < MAXN) begin
        line_w[wr_idx] = v;
        stop_w[wr_idx] = sb;
        wr_idx++;
      end
    end
  endtask

  // Frame-level reference: every falling edge seen while the receiver is free
  // starts either a qualified frame (line low at the mid-bit sample) or a
  // rejected start. Timing is expressed as offsets from the edge sample.
  task automatic build_model(input int n);
    int  free_at;
    bit  fe_cur;
    bit  prev;
    free_at = 0;
    for (int k = 0; k < MAXN; k++) begin
      m_en[k] = 0; m_ld[k] = 0; m_fs[k] = 0; m_fe[k] = 0; m_busy[k] = 0;
      fe_evt[k] = -1;
    end
    for (int t = 0; t < n; t++) begin
      prev = (t == 0) ? 1'b1 : line_w[t-1];
      if (prev && !line_w[t] && t >= free_at) begin
        if (t + HB < n && !line_w[t+HB]) begin
          for (int k = t + 2; k <= t + LOAD_AT && k < n; k++) m_busy[k] = 1;
          for (int k = t + LAT_EN; k < t + STOP_CHK && k < n; k++) m_en[k] = 1;
          if (t + LAT_EN < n) fe_evt[t+LAT_EN] = 0;
          if (t + LOAD_AT < n) begin
            if (stop_w[t+LOAD_AT]) m_ld[t+LOAD_AT] = 1;
            else if (t + LOAD_AT + 1 < n) fe_evt[t+LOAD_AT+1] = 1;
          end
          free_at = t + LOAD_AT;
        end else begin
          for (int k = t + 2; k < t + LAT_EN && k < n; k++) m_busy[k] = 1;
          if (t + LAT_EN < n) m_fs[t+LAT_EN] = 1;
          free_at = t + LAT_EN - 1;
        end
      end
    end
    fe_cur = fe_start;
    for (int k = 0; k < n; k++) begin
      if (fe_evt[k] >= 0) fe_cur = fe_evt[k][0];
      m_fe[k] = fe_cur;
    end
  endtask

  // Drive the waveform, emulate the bit timer, and compare every cycle.
  task automatic run_wave(input int n);
    bit [4:0] exp_v;
    run_id++;
    build_model(n);
    tcnt = 0;
    packet_done = 1'b0;
    for (int k = 0; k < n; k++) begin
      serial_in = line_w[k];
      stop_bit  = stop_w[k];
      @(posedge clk);
      #1;
      obs[k] = {enable_timer, load_buffer, false_start, framing_error, rx_busy};
      exp_v  = {m_en[k], m_ld[k], m_fs[k], m_fe[k], m_busy[k]};
      check($sformatf("run%0d cycle%0d {en,ld,fs,fe,busy}", run_id, k),
            32'(obs[k]), 32'(exp_v));
      if ((load_buffer && false_start) || (load_buffer && enable_timer))
        invariant_bad++;
      if (enable_timer === 1'b1) begin
        tcnt++;
        packet_done = (tcnt >= TIMER);
      end else begin
        tcnt = 0;
        packet_done = 1'b0;
      end
    end
    fe_start = m_fe[n-1];
  endtask

  task automatic window_stats(input int s, input int len, output int ld,
                              output int fs, output int en, output int rise,
                              output bit fe);
    ld = 0; fs = 0; en = 0; rise = -1;
    for (int k = s; k < s + len; k++) begin
      ld += int'(obs[k][3]);
      fs += int'(obs[k][2]);
      en += int'(obs[k][4]);
      if (obs[k][4] && rise < 0) rise = k - s;
    end
    fe = obs[s+len-1][1];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld, fs, en, rise;
    bit fe;
    int n;
    int kind;

    tbl[0] = '{2,   1'b1, 0, 1, 0,  -1, 1'b0};  // short glitch
    tbl[1] = '{5,   1'b1, 0, 1, 0,  -1, 1'b0};  // high exactly at mid-bit sample
    tbl[2] = '{6,   1'b1, 1, 0, 90,  7, 1'b0};  // low at mid-bit sample: accepted
    tbl[3] = '{10,  1'b1, 1, 0, 90,  7, 1'b0};  // normal frame
    tbl[4] = '{10,  1'b0, 0, 0, 90,  7, 1'b1};  // bad stop bit
    tbl[5] = '{2,   1'b1, 0, 1, 0,  -1, 1'b1};  // glitch keeps sticky error
    tbl[6] = '{10,  1'b1, 1, 0, 90,  7, 1'b0};  // RECV entry clears error
    tbl[7] = '{200, 1'b1, 1, 0, 90,  7, 1'b0};  // break: no restart
    tbl[8] = '{10,  1'b0, 0, 0, 90,  7, 1'b1};  // error again

    // Reset with idle line.
    rst = 1'b1; serial_in = 1'b1; packet_done = 1'b0; stop_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs {en,ld,fs,fe,busy}",
          32'({enable_timer, load_buffer, false_start, framing_error, rx_busy}), 0);
    @(negedge clk);
    rst = 1'b0;
    fe_start = 1'b0;

    // Idle line for 20 clocks: nothing happens.
    wr_idx = 0;
    put(1'b1, 20, 1'b1);
    run_wave(wr_idx);

    // Table-driven frames, applied back to back in one waveform.
    wr_idx = 0;
    put(1'b1, 5, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tbl_start[i] = wr_idx;
      tbl_len[i]   = ((tbl[i].low_len > 100) ? tbl[i].low_len : 100) + 20;
      put(1'b0, tbl[i].low_len, tbl[i].stop);
      put(1'b1, tbl_len[i] - tbl[i].low_len, tbl[i].stop);
    end
    put(1'b1, 5, 1'b1);
    run_wave(wr_idx);
    for (int i = 0; i < 9; i++) begin
      window_stats(tbl_start[i], tbl_len[i], ld, fs, en, rise, fe);
      check($sformatf("vec%0d load pulses", i), ld, tbl[i].exp_ld);
      check($sformatf("vec%0d false_start pulses", i), fs, tbl[i].exp_fs);
      check($sformatf("vec%0d enable cycles", i), en, tbl[i].exp_en);
      check($sformatf("vec%0d enable latency", i), rise, tbl[i].exp_rise);
      check($sformatf("vec%0d framing_error", i), 32'(fe), 32'(tbl[i].exp_fe));
    end

    // Two frames one idle bit apart, with a falling edge injected in RECV.
    wr_idx = 0;
    put(1'b1, 5, 1'b1);
    put(1'b0, 10, 1'b1); put(1'b1, 30, 1'b1);
    put(1'b0, 10, 1'b1); put(1'b1, 60, 1'b1);
    put(1'b0, 10, 1'b1); put(1'b1, 130, 1'b1);
    run_wave(wr_idx);
    window_stats(0, wr_idx, ld, fs, en, rise, fe);
    check("b2b load pulses", ld, 2);
    check("b2b false_start pulses", fs, 0);
    check("b2b enable cycles", en, 2 * TIMER);

    // Reset 30 clocks into RECV.
    wr_idx = 0;
    put(1'b1, 5, 1'b1);
    put(1'b0, 10, 1'b1);
    put(1'b1, LAT_EN + 30 - 10, 1'b1);
    run_wave(wr_idx);
    check("enable before mid-RECV reset", 32'(enable_timer), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset drops enable_timer", 32'(enable_timer), 0);
    check("async reset drops rx_busy", 32'(rx_busy), 0);
    check("async reset {ld,fs,fe}",
          32'({load_buffer, false_start, framing_error}), 0);
    @(negedge clk);
    rst = 1'b0;
    fe_start = 1'b0;
    wr_idx = 0;
    put(1'b1, 20, 1'b1);
    put(1'b0, 10, 1'b1);
    put(1'b1, 120, 1'b1);
    run_wave(wr_idx);
    window_stats(0, 20, ld, fs, en, rise, fe);
    check("post-reset idle activity", ld + fs + en, 0);
    window_stats(20, wr_idx - 20, ld, fs, en, rise, fe);
    check("post-reset enable latency", rise, LAT_EN);
    check("post-reset load pulses", ld, 1);

    // Randomized line activity: glitches, frames with data, breaks.
    for (int r = 0; r < 3; r++) begin
      wr_idx = 0;
      put(1'b1, 5, 1'b1);
      while (wr_idx < 2500) begin
        put(1'b1, int'($urandom_range(1, 15)), 1'b1);
        kind = int'($urandom_range(0, 3));
        stop_bit = 1'($urandom_range(0, 1));
        case (kind)
          0: put(1'b0, int'($urandom_range(1, 5)), stop_bit);
          1: put(1'b0, int'($urandom_range(6, 12)), stop_bit);
          2: begin
            put(1'b0, 10, stop_bit);
            for (int b = 0; b < 8; b++) put(1'($urandom_range(0, 1)), 10, stop_bit);
            put(1'b1, 10, stop_bit);
          end
          default: put(1'b0, int'($urandom_range(100, 150)), stop_bit);
        endcase
      end
      put(1'b1, 120, 1'b1);
      n = wr_idx;
      run_wave(n);
    end

    check("output exclusivity violations", invariant_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
